test_data_gen: RTL and testbench



---
 rtl/test_data_gen_pkg.sv | 35 +++
 rtl/test_data_gen_core.sv | 151 +++++++++++++++
 rtl/test_data_gen.sv | 114 +++++++++++
 tb/tb_test_data_gen.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_data_gen_pkg.sv
// Shared encodings, register offsets and LFSR constants for the test_data_gen stream source.
package test_data_gen_pkg;

    typedef enum logic [1:0] {
        MODE_COUNTER = 2'd0,
        MODE_PATTERN = 2'd1,
        MODE_WALK    = 2'd2,
        MODE_LFSR    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] REG_RESET    = 4'd0;
    localparam logic [3:0] REG_START    = 4'd1;
    localparam logic [3:0] REG_CONF     = 4'd2;
    localparam logic [3:0] REG_BURST0   = 4'd3;
    localparam logic [3:0] REG_PATTERN0 = 4'd7;
    localparam logic [3:0] REG_STATUS   = 4'd15;

    localparam logic [7:0] VERSION = 8'd1;

    // Fibonacci taps for x^31 + x^28 + 1 over a 31-bit state
    localparam logic [4:0]  LFSR_TAP_A = 5'd30;
    localparam logic [4:0]  LFSR_TAP_B = 5'd27;
    localparam logic [30:0] LFSR_SEED  = '1;

    function automatic logic [30:0] lfsr_step(input logic [30:0] s);
        return {s[29:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
    endfunction

endpackage

// File: rtl/test_data_gen_core.sv
// Stream engine: run control, word/sent counters and word generation (no bus logic).
// Mode 3 produces an LFSR sequence only when TEST_DATA_GEN_LFSR_EN is defined.
module test_data_gen_core
    import test_data_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  soft_rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] pattern,
    input  logic [CNT_WIDTH-1:0]  burst_len,
    input  logic                  data_read,
    output logic                  data_empty,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  sent
);
    localparam int unsigned NB = DATA_WIDTH / 8;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  n_q, n_d;
    logic [CNT_WIDTH-1:0]  sent_q, sent_d, sent_inc;
    logic                  done_q, done_d;
    logic                  empty_q, empty_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  start_run, advance;

    function automatic logic [DATA_WIDTH-1:0] gen_word(input logic [1:0]            m,
                                                       input logic [CNT_WIDTH-1:0]  idx,
                                                       input logic [DATA_WIDTH-1:0] pat);
        logic [DATA_WIDTH-1:0] w;
        logic [7:0]            base;
        logic [CNT_WIDTH-1:0]  bit_pos;
        w       = '0;
        base    = idx[7:0] * 8'(NB);
        bit_pos = idx % CNT_WIDTH'(DATA_WIDTH);
        case (mode_e'(m))
            MODE_PATTERN: w = pat;
            MODE_WALK: for (int unsigned b = 0; b < DATA_WIDTH; b++) w[b] = (bit_pos == CNT_WIDTH'(b));
            default: for (int unsigned k = 0; k < NB; k++) w[8*k +: 8] = base + 8'(k);
        endcase
        return w;
    endfunction

    assign sent_inc = sent_q + CNT_WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        sent_d    = sent_q;
        done_d    = done_q;
        empty_d   = empty_q;
        start_run = 1'b0;
        advance   = 1'b0;
        if (soft_rst) begin
            state_d = IDLE;
            n_d     = '0;
            sent_d  = '0;
            done_d  = 1'b0;
            empty_d = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (stop) begin
                        state_d = IDLE;
                        empty_d = 1'b1;
                    end else if (data_read && !empty_q) begin
                        sent_d = (sent_q == '1) ? sent_q : sent_inc;
                        if ((burst_len != '0) && (sent_inc == burst_len)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            empty_d = 1'b1;
                        end else begin
                            advance = 1'b1;
                            n_d     = n_q + CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_d   = RUN;
                        start_run = 1'b1;
                        n_d       = '0;
                        sent_d    = '0;
                        done_d    = 1'b0;
                        empty_d   = 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef TEST_DATA_GEN_LFSR_EN
    logic [30:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (soft_rst || start_run) lfsr_d = LFSR_SEED;
        else if (advance)          lfsr_d = lfsr_step(lfsr_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= lfsr_d;
    end
`endif

    always_comb begin
        data_d = data_q;
        if (soft_rst) begin
            data_d = '0;
        end else if (start_run || advance) begin
            data_d = gen_word(mode, n_d, pattern);
`ifdef TEST_DATA_GEN_LFSR_EN
            // each 32-bit lane carries {0, state}
            if (mode_e'(mode) == MODE_LFSR) data_d = DATA_WIDTH'({2{1'b0, lfsr_d}});
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            sent_q  <= '0;
            done_q  <= 1'b0;
            empty_q <= 1'b1;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            sent_q  <= sent_d;
            done_q  <= done_d;
            empty_q <= empty_d;
            data_q  <= data_d;
        end
    end

    assign data_empty = empty_q;
    assign data       = data_q;
    assign busy       = (state_q == RUN);
    assign done       = done_q;
    assign sent       = sent_q;

endmodule

// File: rtl/test_data_gen.sv
// Basil-bus test-data source: address decode, register file and readback around test_data_gen_core.
// Define TEST_DATA_GEN_LFSR_EN to give mode 3 an LFSR sequence (otherwise it aliases COUNTER).
module test_data_gen
    import test_data_gen_pkg::*;
#(
    parameter int unsigned BASEADDR   = 16'h0000,
    parameter int unsigned HIGHADDR   = 16'h000f,
    parameter int unsigned ABUSWIDTH  = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST,
    input  logic [ABUSWIDTH-1:0]  BUS_ADD,
    inout  wire  [7:0]            BUS_DATA,
    input  logic                  BUS_RD,
    input  logic                  BUS_WR,
    input  logic                  EXT_START,
    input  logic                  DATA_READ,
    output logic                  DATA_EMPTY,
    output logic [DATA_WIDTH-1:0] DATA,
    output logic                  BUSY
);
    logic [ABUSWIDTH-1:0] rel;
    logic [3:0]           offs;
    logic                 hit, wr_hit;
    logic [2:0]           conf_q;
    logic [31:0]          burst_q;
    logic [63:0]          pattern_q;
    logic                 ext_q;
    logic [7:0]           rd_data_q, rd_data_d;
    logic                 rd_valid_q;
    logic                 soft_rst, start, stop, busy, done;
    logic [CNT_WIDTH-1:0] sent;
    logic [31:0]          sent32;

    // Below-base addresses wrap to large offsets, so one compare covers both bounds
    assign rel    = BUS_ADD - ABUSWIDTH'(BASEADDR);
    assign hit    = (rel <= ABUSWIDTH'(HIGHADDR - BASEADDR));
    assign offs   = rel[3:0];
    assign wr_hit = hit && BUS_WR;

    assign soft_rst = wr_hit && (offs == REG_RESET);
    assign stop     = wr_hit && (offs == REG_CONF) && BUS_DATA[3];
    assign start    = (wr_hit && (offs == REG_START)) || (EXT_START && !ext_q && conf_q[2]);
    assign sent32   = 32'(sent);

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            conf_q    <= '0;
            burst_q   <= '0;
            pattern_q <= '0;
            ext_q     <= 1'b0;
        end else begin
            ext_q <= EXT_START;
            if (wr_hit) begin
                if (offs == REG_CONF) conf_q <= BUS_DATA[2:0];
                for (int unsigned i = 0; i < 4; i++)
                    if (!busy && (offs == 4'(REG_BURST0 + i))) burst_q[8*i +: 8] <= BUS_DATA;
                for (int unsigned i = 0; i < 8; i++)
                    if (offs == 4'(REG_PATTERN0 + i)) pattern_q[8*i +: 8] <= BUS_DATA;
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        case (offs)
            REG_RESET:  rd_data_d = VERSION;
            REG_CONF:   rd_data_d = {5'd0, conf_q};
            REG_STATUS: rd_data_d = {6'd0, busy, done};
            default:    rd_data_d = '0;
        endcase
        for (int unsigned i = 0; i < 4; i++)
            if (offs == 4'(REG_BURST0 + i)) rd_data_d = sent32[8*i +: 8];
        for (int unsigned i = 0; i < 8; i++)
            if (offs == 4'(REG_PATTERN0 + i)) rd_data_d = pattern_q[8*i +: 8];
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= hit && BUS_RD;
        end
    end

    assign BUS_DATA = rd_valid_q ? rd_data_q : 8'hzz;

    test_data_gen_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_core (
        .clk       (BUS_CLK),
        .rst       (BUS_RST),
        .soft_rst  (soft_rst),
        .start     (start),
        .stop      (stop),
        .mode      (conf_q[1:0]),
        .pattern   (pattern_q[DATA_WIDTH-1:0]),
        .burst_len (CNT_WIDTH'(burst_q)),
        .data_read (DATA_READ),
        .data_empty(DATA_EMPTY),
        .data      (DATA),
        .busy      (busy),
        .done      (done),
        .sent      (sent)
    );

    assign BUSY = busy;

endmodule

// File: tb/tb_test_data_gen.sv
// Randomised self-checking bench for test_data_gen against a word-index reference model.
module tb_test_data_gen;

    localparam int unsigned DW = 32;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic [15:0]   bus_add   = '0;
    wire  [7:0]    bus_data;
    logic [7:0]    drv       = '0;
    logic          drv_en    = 1'b0;
    logic          bus_rd    = 1'b0;
    logic          bus_wr    = 1'b0;
    logic          ext_start = 1'b0;
    logic          data_read = 1'b0;
    logic          data_empty, busy;
    logic [DW-1:0] data;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;
    assign bus_data = drv_en ? drv : 8'hzz;

    test_data_gen #(
        .BASEADDR  (16'h0000),
        .HIGHADDR  (16'h000f),
        .ABUSWIDTH (16),
        .DATA_WIDTH(DW),
        .CNT_WIDTH (32)
    ) dut (
        .BUS_CLK   (clk),
        .BUS_RST   (rst),
        .BUS_ADD   (bus_add),
        .BUS_DATA  (bus_data),
        .BUS_RD    (bus_rd),
        .BUS_WR    (bus_wr),
        .EXT_START (ext_start),
        .DATA_READ (data_read),
        .DATA_EMPTY(data_empty),
        .DATA      (data),
        .BUSY      (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // State after `steps` shifts from all-ones; new bit = x^31 term xor x^28 term
    function automatic logic [30:0] ref_lfsr(input int unsigned steps);
        int unsigned s = 32'h7FFF_FFFF;
        for (int unsigned i = 0; i < steps; i++) begin
            int unsigned fb = ((s >> 30) ^ (s >> 27)) & 1;
            s = ((s << 1) | fb) & 32'h7FFF_FFFF;
        end
        return 31'(s);
    endfunction

    function automatic logic [31:0] ref_word(input int unsigned mode, input int unsigned n,
                                             input logic [31:0] pat);
        logic [31:0] w = '0;
        case (mode)
            1: w = pat;
            2: w = 32'd1 << (n % 32);
`ifdef TEST_DATA_GEN_LFSR_EN
            3: w = {1'b0, ref_lfsr(n)};
`endif
            default: for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'((n * 4 + k) % 256);
        endcase
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        bus_add = {12'h000, a};
        drv     = d;
        drv_en  = 1'b1;
        bus_wr  = 1'b1;
        tick();
        bus_wr  = 1'b0;
        drv_en  = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        bus_add = {12'h000, a};
        bus_rd  = 1'b1;
        tick();
        bus_rd  = 1'b0;
        d       = bus_data;
        tick();
    endtask

    task automatic read_sent(output logic [31:0] v);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            bus_read(4'(3 + i), b);
            v[8*i +: 8] = b;
        end
    endtask

    task automatic set_burst(input logic [31:0] v);
        for (int i = 0; i < 4; i++) bus_write(4'(3 + i), v[8*i +: 8]);
    endtask

    task automatic set_pattern(input logic [31:0] p);
        for (int i = 0; i < 4; i++) bus_write(4'(7 + i), p[8*i +: 8]);
        for (int i = 0; i < 4; i++) bus_write(4'(11 + i), 8'h00);
    endtask

    // Pops npops words starting at word index n0, checking every presented word
    task automatic stream(input int unsigned mode, input int unsigned n0, input int unsigned npops,
                          input logic [31:0] pat, input int unsigned pct);
        int unsigned n      = n0;
        int unsigned popped = 0;
        int unsigned cyc    = 0;
        logic        pop;
        while (popped < npops && cyc < 2000) begin
            check_eq("run empty", data_empty, 1'b0);
            if (!data_empty) check_eq("word", data, ref_word(mode, n, pat));
            data_read = ($urandom_range(99) < pct);
            pop       = data_read && !data_empty;
            tick();
            if (pop) begin
                n++;
                popped++;
            end
            cyc++;
        end
        data_read = 1'b0;
        if (popped < npops) check_eq("stream timeout", popped, npops);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  b;
        logic [31:0] v;
        int unsigned mode, len, pct;
        logic [31:0] pat;

        repeat (2) tick();
        check_eq("reset empty", data_empty, 1'b1);
        check_eq("reset busy", busy, 1'b0);
        check_eq("reset data", data, 32'h0);
        rst = 1'b0;
        tick();
        bus_read(4'd0, b);
        check_eq("version", b, 8'h01);

        // counter burst with DATA_READ held high
        bus_write(4'd2, 8'h00);
        set_burst(4);
        bus_write(4'd1, 8'h00);
        check_eq("first counter word", data, 32'h0302_0100);
        stream(0, 0, 4, 32'h0, 100);
        check_eq("burst end empty", data_empty, 1'b1);
        check_eq("burst end busy", busy, 1'b0);
        bus_read(4'd15, b);
        check_eq("status done", b, 8'h01);
        read_sent(v);
        check_eq("sent after counter", v, 32'd4);

        // pattern burst with sparse reads; extra reads after DONE must not pop
        set_pattern(32'hDEAD_BEEF);
        bus_write(4'd2, 8'h01);
        set_burst(3);
        bus_write(4'd1, 8'h00);
        stream(1, 0, 3, 32'hDEAD_BEEF, 50);
        data_read = 1'b1;
        repeat (4) tick();
        data_read = 1'b0;
        check_eq("pattern empty after done", data_empty, 1'b1);
        read_sent(v);
        check_eq("sent after pattern", v, 32'd3);

        // continuous walking-one, BURST_LEN write mid-run ignored, then STOP
        bus_write(4'd2, 8'h02);
        set_burst(0);
        bus_write(4'd1, 8'h00);
        stream(2, 0, 20, 32'h0, 70);
        set_burst(21);
        stream(2, 20, 20, 32'h0, 70);
        bus_write(4'd2, 8'h0A);
        check_eq("busy after stop", busy, 1'b0);
        check_eq("empty after stop", data_empty, 1'b1);
        read_sent(v);
        check_eq("sent after stop", v, 32'd40);
        bus_read(4'd2, b);
        check_eq("stop self-clears", b, 8'h02);
        bus_read(4'd15, b);
        check_eq("status idle", b, 8'h00);

        // external start: a 3-cycle pulse gives exactly one run
        bus_write(4'd2, 8'h04);
        set_burst(5);
        ext_start = 1'b1;
        data_read = 1'b1;
        repeat (3) tick();
        ext_start = 1'b0;
        data_read = 1'b0;
        check_eq("ext busy", busy, 1'b1);
        check_eq("ext word after 2 pops", data, ref_word(0, 2, 32'h0));
        stream(0, 2, 1, 32'h0, 100);
        bus_write(4'd1, 8'h00);
        read_sent(v);
        check_eq("start in run ignored", v, 32'd3);
        stream(0, 3, 2, 32'h0, 100);
        bus_read(4'd15, b);
        check_eq("ext run done", b, 8'h01);
        bus_write(4'd2, 8'h00);
        ext_start = 1'b1;
        repeat (2) tick();
        ext_start = 1'b0;
        check_eq("ext start disabled", busy, 1'b0);

        // asynchronous hard reset between clock edges
        set_burst(10);
        bus_write(4'd1, 8'h00);
        stream(0, 0, 3, 32'h0, 100);
        bus_write(4'd2, 8'h01);
        #2 rst = 1'b1;
        #1;
        check_eq("async rst empty", data_empty, 1'b1);
        check_eq("async rst busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        bus_read(4'd2, b);
        check_eq("conf after hard reset", b, 8'h00);
        read_sent(v);
        check_eq("sent after hard reset", v, 32'd0);

        // mode 3
        bus_write(4'd2, 8'h03);
        set_burst(2);
        bus_write(4'd1, 8'h00);
`ifdef TEST_DATA_GEN_LFSR_EN
        check_eq("mode3 first word", data, 32'h7FFF_FFFF);
`else
        check_eq("mode3 first word", data, 32'h0302_0100);
`endif
        stream(3, 0, 2, 32'h0, 100);
        bus_read(4'd15, b);
        check_eq("mode3 done", b, 8'h01);

        // soft reset keeps configuration
        pat = $urandom;
        set_pattern(pat);
        bus_write(4'd2, 8'h01);
        set_burst(0);
        bus_write(4'd1, 8'h00);
        stream(1, 0, 5, pat, 80);
        bus_write(4'd0, 8'h55);
        check_eq("soft rst busy", busy, 1'b0);
        check_eq("soft rst empty", data_empty, 1'b1);
        check_eq("soft rst data", data, 32'h0);
        bus_read(4'd2, b);
        check_eq("conf kept on soft reset", b, 8'h01);
        read_sent(v);
        check_eq("sent after soft reset", v, 32'd0);

        // randomised bursts
        repeat (6) begin
            mode = $urandom_range(3);
            len  = $urandom_range(20, 1);
            pct  = $urandom_range(90, 20);
            pat  = $urandom;
            set_pattern(pat);
            bus_write(4'd2, 8'(mode));
            set_burst(len);
            bus_write(4'd1, 8'h00);
            stream(mode, 0, len, pat, pct);
            check_eq("rand end empty", data_empty, 1'b1);
            read_sent(v);
            check_eq("rand sent", v, len);
            bus_read(4'd15, b);
            check_eq("rand status", b, 8'h01);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
